// File: rtl/rc4_s_mem_sequencer_if.sv
// Bus between the RC4 phase sequencer, the top level, the three phase engines and the
// S-memory write/address port.
interface rc4_s_mem_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              go;
  logic              abort;
  logic              busy;
  logic              done;
  logic              fault;
  logic [1:0]        phase;
  logic              init_start;
  logic              ksa_start;
  logic              prga_start;
  logic              init_finish;
  logic              ksa_finish;
  logic              prga_finish;
  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] ksa_addr;
  logic [ADDR_W-1:0] prga_addr;
  logic [DATA_W-1:0] init_data;
  logic [DATA_W-1:0] ksa_data;
  logic [DATA_W-1:0] prga_data;
  logic              init_wren;
  logic              ksa_wren;
  logic              prga_wren;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              s_wren;

  modport master (
    input  go, abort,
    input  init_finish, ksa_finish, prga_finish,
    input  init_addr, ksa_addr, prga_addr,
    input  init_data, ksa_data, prga_data,
    input  init_wren, ksa_wren, prga_wren,
    output busy, done, fault, phase,
    output init_start, ksa_start, prga_start,
    output s_addr, s_data, s_wren
  );

  modport slave (
    output go, abort,
    output init_finish, ksa_finish, prga_finish,
    output init_addr, ksa_addr, prga_addr,
    output init_data, ksa_data, prga_data,
    output init_wren, ksa_wren, prga_wren,
    input  busy, done, fault, phase,
    input  init_start, ksa_start, prga_start,
    input  s_addr, s_data, s_wren
  );
endinterface

// File: rtl/rc4_s_mem_sequencer.sv
// RC4 phase controller: runs init, KSA and PRGA in order, grants the single S-memory
// write/address port to the active engine and guards every phase with a watchdog.
module rc4_s_mem_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   reset,
  rc4_s_mem_sequencer_if.master bus
);

  // One-hot encoding keeps every decoded output a single-bit function of the state.
  typedef enum logic [8:0] {
    S_IDLE     = 9'b000000001,
    S_INIT_REQ = 9'b000000010,
    S_INIT_RUN = 9'b000000100,
    S_KSA_REQ  = 9'b000001000,
    S_KSA_RUN  = 9'b000010000,
    S_PRGA_REQ = 9'b000100000,
    S_PRGA_RUN = 9'b001000000,
    S_DONE     = 9'b010000000,
    S_ERROR    = 9'b100000000
  } state_e;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_e            state_r;
  state_e            next_state_s;
  logic [15:0]       wdog_r;
  logic [1:0]        phase_s;
  logic              in_req_s;
  logic              in_run_s;
  logic              finish_sel_s;
  logic              wd_expired_s;
  logic [ADDR_W-1:0] s_addr_s;
  logic [DATA_W-1:0] s_data_s;
  logic              s_wren_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Phase decode and selection of the granted engine's finish
  always_comb begin
    phase_s      = 2'b00;
    in_req_s     = 1'b0;
    in_run_s     = 1'b0;
    finish_sel_s = 1'b0;
    case (state_r)
      S_INIT_REQ: begin phase_s = 2'b01; in_req_s = 1'b1; end
      S_INIT_RUN: begin phase_s = 2'b01; in_run_s = 1'b1; finish_sel_s = bus.init_finish; end
      S_KSA_REQ:  begin phase_s = 2'b10; in_req_s = 1'b1; end
      S_KSA_RUN:  begin phase_s = 2'b10; in_run_s = 1'b1; finish_sel_s = bus.ksa_finish; end
      S_PRGA_REQ: begin phase_s = 2'b11; in_req_s = 1'b1; end
      S_PRGA_RUN: begin phase_s = 2'b11; in_run_s = 1'b1; finish_sel_s = bus.prga_finish; end
      default:    begin phase_s = 2'b00; end
    endcase
  end

  // A finish in the last allowed cycle beats the timeout.
  assign wd_expired_s = in_run_s && !finish_sel_s && (wdog_r == WD_LIMIT);

  // Next-state logic; abort outranks everything else
  always_comb begin
    next_state_s = state_r;
    if (bus.abort) begin
      next_state_s = S_IDLE;
    end else if (wd_expired_s) begin
      next_state_s = S_ERROR;
    end else begin
      case (state_r)
        S_IDLE:     next_state_s = bus.go ? S_INIT_REQ : S_IDLE;
        S_INIT_REQ: next_state_s = S_INIT_RUN;
        S_INIT_RUN: next_state_s = finish_sel_s ? S_KSA_REQ : S_INIT_RUN;
        S_KSA_REQ:  next_state_s = S_KSA_RUN;
        S_KSA_RUN:  next_state_s = finish_sel_s ? S_PRGA_REQ : S_KSA_RUN;
        S_PRGA_REQ: next_state_s = S_PRGA_RUN;
        S_PRGA_RUN: next_state_s = finish_sel_s ? S_DONE : S_PRGA_RUN;
        S_DONE:     next_state_s = S_IDLE;
        S_ERROR:    next_state_s = S_ERROR;
        default:    next_state_s = S_IDLE;
      endcase
    end
  end

  // Per-phase watchdog: cleared on each request, counts RUN cycles without finish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_r <= 16'd0;
    end else if (bus.abort || in_req_s) begin
      wdog_r <= 16'd0;
    end else if (in_run_s && !finish_sel_s) begin
      wdog_r <= wdog_r + 16'd1;
    end else begin
      wdog_r <= wdog_r;
    end
  end

  // S-memory grant mux; an ungranted requester never reaches the port
  always_comb begin
    s_addr_s = '0;
    s_data_s = '0;
    s_wren_s = 1'b0;
    case (phase_s)
      2'b01:   begin s_addr_s = bus.init_addr; s_data_s = bus.init_data; s_wren_s = bus.init_wren; end
      2'b10:   begin s_addr_s = bus.ksa_addr;  s_data_s = bus.ksa_data;  s_wren_s = bus.ksa_wren;  end
      2'b11:   begin s_addr_s = bus.prga_addr; s_data_s = bus.prga_data; s_wren_s = bus.prga_wren; end
      default: begin s_addr_s = '0; s_data_s = '0; s_wren_s = 1'b0; end
    endcase
  end

  assign bus.phase      = phase_s;
  assign bus.busy       = (phase_s != 2'b00);
  assign bus.done       = (state_r == S_DONE);
  assign bus.fault      = (state_r == S_ERROR);
  assign bus.init_start = (state_r == S_INIT_REQ);
  assign bus.ksa_start  = (state_r == S_KSA_REQ);
  assign bus.prga_start = (state_r == S_PRGA_REQ);
  assign bus.s_addr     = s_addr_s;
  assign bus.s_data     = s_data_s;
  assign bus.s_wren     = s_wren_s;

endmodule
